// File: rtl/fp_sub_1d5_pkg.sv
// Shared types and defaults for the fp_sub_1d5 arbiter slice.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package fp_sub_1d5_pkg;
    localparam int FLOAT_W       = 31;
    localparam int NUM_REQ       = 2;
    localparam int PIPE_LAT_DEF  = 2;
    localparam int TAG_DEPTH_DEF = 4;

    // Requester id: which Newton stage owns an in-flight operation.
    typedef logic [0:0] req_id_t;

    // Contents of the registered response slot (full bit kept separately).
    typedef struct packed {
        logic [FLOAT_W-1:0] float_v;
        logic [FLOAT_W-1:0] delay;
        logic               err;
        req_id_t            id;
    } slot_t;

    // Saturating 16-bit increment for the statistics counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/fp_sub_1d5_arbiter_if.sv
// Bundle of requester, shared-pipe and response signals of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: req_ready / sub_backprn / resp_ready travel through here.
// Modports: slave = arbiter side, master = environment (requesters + pipe).
interface fp_sub_1d5_arbiter_if;
    import fp_sub_1d5_pkg::*;

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [FLOAT_W-1:0] req_float0;
    logic [FLOAT_W-1:0] req_float1;
    logic [FLOAT_W-1:0] req_delay0;
    logic [FLOAT_W-1:0] req_delay1;
    logic [NUM_REQ-1:0] req_error;

    logic               sub_valid;
    logic [FLOAT_W-1:0] sub_float_in;
    logic [FLOAT_W-1:0] sub_float_in_delay;
    logic               sub_error_in;
    logic               sub_backprn;
    logic               sub_ready;
    logic [FLOAT_W-1:0] sub_float_out;
    logic [FLOAT_W-1:0] sub_float_out_delay;
    logic               sub_error_out;

    logic [NUM_REQ-1:0] resp_valid;
    logic [NUM_REQ-1:0] resp_ready;
    logic [FLOAT_W-1:0] resp_float;
    logic [FLOAT_W-1:0] resp_delay;
    logic               resp_error;

    modport slave (
        input  req_valid, req_float0, req_float1, req_delay0, req_delay1, req_error,
        output req_ready,
        output sub_valid, sub_float_in, sub_float_in_delay, sub_error_in, sub_backprn,
        input  sub_ready, sub_float_out, sub_float_out_delay, sub_error_out,
        output resp_valid, resp_float, resp_delay, resp_error,
        input  resp_ready
    );

    modport master (
        output req_valid, req_float0, req_float1, req_delay0, req_delay1, req_error,
        input  req_ready,
        input  sub_valid, sub_float_in, sub_float_in_delay, sub_error_in, sub_backprn,
        output sub_ready, sub_float_out, sub_float_out_delay, sub_error_out,
        input  resp_valid, resp_float, resp_delay, resp_error,
        output resp_ready
    );
endinterface

// File: rtl/fp_1d5_tag_fifo.sv
// Synchronous FIFO of requester tags, one per operation in flight in the pipe.
// Latency: push visible at dout the cycle after; dout is the head, read combinationally.
// Backpressure: push ignored when full, pop ignored when empty (caller gates both).
// Ports: clk, rst (sync, active-high), push/din, pop/dout, full, empty.
module fp_1d5_tag_fifo
    import fp_sub_1d5_pkg::*;
#(
    parameter int DEPTH = TAG_DEPTH_DEF
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  req_id_t din,
    input  logic    pop,
    output req_id_t dout,
    output logic    full,
    output logic    empty
);
    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit separates full (MSBs differ) from empty (equal).
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    req_id_t     mem_q [DEPTH];
    req_id_t     mem_d [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: rtl/fp_sub_1d5_arbiter.sv
// Round-robin share of one fp_sub_1d5_pipe between two Newton stages, results routed by tag.
// Latency: operand issued at T -> pipe result at T+PIPE_LAT -> resp_valid at T+PIPE_LAT+1.
// Backpressure: an unaccepted response slot raises sub_backprn, freezing pipe and issue.
// Ports: clk, rst (sync, active-high), bus (fp_sub_1d5_arbiter_if.slave);
//        stat_issue0/stat_issue1/stat_stall exist only when FP1D5_ARB_STATS_EN is defined.
module fp_sub_1d5_arbiter
    import fp_sub_1d5_pkg::*;
#(
    parameter int PIPE_LAT  = PIPE_LAT_DEF,
    parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
    input  logic clk,
    input  logic rst,
    fp_sub_1d5_arbiter_if.slave bus
`ifdef FP1D5_ARB_STATS_EN
    ,
    output logic [15:0] stat_issue0,
    output logic [15:0] stat_issue1,
    output logic [15:0] stat_stall
`endif
);
    // The tag FIFO must cover every pipe stage plus the capture cycle, or
    // back-to-back issue would stall on tags; a too-small depth is rounded up.
    localparam int MIN_DEPTH  = PIPE_LAT + 1;
    localparam int FIFO_DEPTH = (TAG_DEPTH >= MIN_DEPTH) ? TAG_DEPTH : (2 ** $clog2(MIN_DEPTH));

    req_id_t last_grant_q, last_grant_d;
    logic    slot_full_q, slot_full_d;
    slot_t   slot_q, slot_d;

    req_id_t grant;
    req_id_t tag_dout;
    logic    tag_full, tag_empty;
    logic    issue, xfer, capture, backprn;

    assign backprn = slot_full_q && !bus.resp_ready[slot_q.id];
    assign issue   = !backprn && !tag_full;
    assign xfer    = issue && bus.req_valid[grant];
    // A result with no tag outstanding has no owner and is dropped.
    assign capture = bus.sub_ready && !backprn && !tag_empty;

    // Lone requester wins outright; on a tie the one not served last wins.
    always_comb begin
        case (bus.req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            default: grant = ~last_grant_q;
        endcase
    end

    always_comb begin
        bus.req_ready        = '0;
        bus.req_ready[grant] = issue;
        bus.sub_valid          = xfer;
        bus.sub_float_in       = '0;
        bus.sub_float_in_delay = '0;
        bus.sub_error_in       = 1'b0;
        if (xfer) begin
            bus.sub_float_in       = grant[0] ? bus.req_float1 : bus.req_float0;
            bus.sub_float_in_delay = grant[0] ? bus.req_delay1 : bus.req_delay0;
            bus.sub_error_in       = bus.req_error[grant];
        end
    end

    assign bus.sub_backprn = backprn;

    fp_1d5_tag_fifo #(.DEPTH(FIFO_DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (xfer),
        .din   (grant),
        .pop   (capture),
        .dout  (tag_dout),
        .full  (tag_full),
        .empty (tag_empty)
    );

    // Release and reload may coincide: capture overrides the release.
    always_comb begin
        last_grant_d = xfer ? grant : last_grant_q;
        slot_full_d  = slot_full_q;
        slot_d       = slot_q;
        if (slot_full_q && bus.resp_ready[slot_q.id]) begin
            slot_full_d = 1'b0;
        end
        if (capture) begin
            slot_full_d    = 1'b1;
            slot_d.float_v = bus.sub_float_out;
            slot_d.delay   = bus.sub_float_out_delay;
            slot_d.err     = bus.sub_error_out;
            slot_d.id      = tag_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            slot_full_q  <= 1'b0;
            slot_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            slot_full_q  <= slot_full_d;
            slot_q       <= slot_d;
        end
    end

    always_comb begin
        bus.resp_valid             = '0;
        bus.resp_valid[slot_q.id]  = slot_full_q;
    end

    assign bus.resp_float = slot_q.float_v;
    assign bus.resp_delay = slot_q.delay;
    assign bus.resp_error = slot_q.err;

`ifdef FP1D5_ARB_STATS_EN
    logic [15:0] stat_issue0_q, stat_issue0_d;
    logic [15:0] stat_issue1_q, stat_issue1_d;
    logic [15:0] stat_stall_q,  stat_stall_d;

    always_comb begin
        stat_issue0_d = stat_issue0_q;
        stat_issue1_d = stat_issue1_q;
        stat_stall_d  = stat_stall_q;
        if (xfer && !grant[0]) stat_issue0_d = sat_inc(stat_issue0_q);
        if (xfer &&  grant[0]) stat_issue1_d = sat_inc(stat_issue1_q);
        if (backprn)           stat_stall_d  = sat_inc(stat_stall_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issue0_q <= '0;
            stat_issue1_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_issue0_q <= stat_issue0_d;
            stat_issue1_q <= stat_issue1_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_issue0 = stat_issue0_q;
    assign stat_issue1 = stat_issue1_q;
    assign stat_stall  = stat_stall_q;
`endif
endmodule
